// File: rtl/usb_pkg.sv
// usb_pkg: shared USB register constants, status bit positions and update helper
//   USB_REG_*      register indices in the USB block
//   USB_STS_*      REG0 status bit positions used by both requesters
//   slot_t         one buffered update {set, clr}
//   apply_update   REG0 value after an update, clear wins over set
package usb_pkg;
   localparam logic [2:0] USB_REG_STATUS = 3'h0;
   localparam logic [2:0] USB_REG_CMD    = 3'h1;
   localparam int USB_STS_RX_READY = 0;
   localparam int USB_STS_TX_READY = 1;
   localparam int USB_STS_CMD_PEND = 2;
   localparam int USB_STS_SNES_CMD = 3;
   localparam int USB_STS_ERROR    = 7;
   typedef struct packed {
      logic [7:0] set;
      logic [7:0] clr;
   } slot_t;
   function automatic logic [7:0] apply_update(input logic [7:0] cur, input slot_t u);
      return (cur | u.set) & ~u.clr;
   endfunction
endpackage

// File: rtl/usb_status_seq_if.sv
// usb_status_seq_if: requester handshakes and USB status update port
//   req/set/clr/ack 0,1   per-requester update handshake
//   status_*              update port towards the USB register block
//   busy, status_shadow   sequencer state for readback/debug
interface usb_status_seq_if;
   logic       req0;
   logic [7:0] set0;
   logic [7:0] clr0;
   logic       ack0;
   logic       req1;
   logic [7:0] set1;
   logic [7:0] clr1;
   logic       ack1;
   logic [7:0] status_set_bits;
   logic [7:0] status_reset_bits;
   logic       status_reset_we;
   logic       busy;
   logic [7:0] status_shadow;
   modport master (
      output req0, set0, clr0, req1, set1, clr1,
      input  ack0, ack1, status_set_bits, status_reset_bits, status_reset_we, busy, status_shadow
   );
   modport slave (
      input  req0, set0, clr0, req1, set1, clr1,
      output ack0, ack1, status_set_bits, status_reset_bits, status_reset_we, busy, status_shadow
   );
endinterface

// File: rtl/usb_status_slot.sv
// usb_status_slot: single-entry update buffer with req/ack capture handshake
//   req_i/set_i/clr_i   requester level request and data
//   grant_i             arbiter takes the entry, slot empties this cycle
//   full_o/data_o       buffered entry
//   ack_o               one-cycle pulse after capture
module usb_status_slot
   import usb_pkg::*;
(
   input  logic       clkin,
   input  logic       rst,
   input  logic       req_i,
   input  logic [7:0] set_i,
   input  logic [7:0] clr_i,
   input  logic       grant_i,
   output logic       full_o,
   output slot_t      data_o,
   output logic       ack_o
);
   logic  full_q, full_d, ack_q, cap;
   slot_t data_q, data_d;
   assign cap    = req_i & ~full_q;
   assign full_d = (full_q & ~grant_i) | cap;
   assign data_d = cap ? slot_t'{set: set_i, clr: clr_i} : data_q;
   always_ff @(posedge clkin) begin
      if (rst) begin
         full_q <= 1'b0;
         ack_q  <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         ack_q  <= cap;
         data_q <= data_d;
      end
   end
   assign full_o = full_q;
   assign data_o = data_q;
   assign ack_o  = ack_q;
endmodule

// File: rtl/usb_status_seq.sv
// usb_status_seq: round-robin sequencer driving timed REG0 status updates
//   clkin, rst   clock and synchronous active-high reset
//   bus          slave side of usb_status_seq_if (requesters + USB update port)
module usb_status_seq
   import usb_pkg::*;
#(
   parameter int WE_HIGH = 2,
   parameter int WE_GAP  = 3
) (
   input logic             clkin,
   input logic             rst,
   usb_status_seq_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   logic [1:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ptr_q, ptr_d, we_q, we_d;
   logic [7:0] shadow_q, shadow_d;
   slot_t      drv_q, drv_d, slot0, slot1;
   logic       full0, full1, grant0, grant1, idle, drive_done, gap_done;
   usb_status_slot u_slot0 (
      .clkin(clkin), .rst(rst), .req_i(bus.req0), .set_i(bus.set0), .clr_i(bus.clr0),
      .grant_i(grant0), .full_o(full0), .data_o(slot0), .ack_o(bus.ack0)
   );
   usb_status_slot u_slot1 (
      .clkin(clkin), .rst(rst), .req_i(bus.req1), .set_i(bus.set1), .clr_i(bus.clr1),
      .grant_i(grant1), .full_o(full1), .data_o(slot1), .ack_o(bus.ack1)
   );
   assign idle       = state_q == ST_IDLE;
   // pointer only matters when both slots compete
   assign grant0     = idle & full0 & (~full1 | ~ptr_q);
   assign grant1     = idle & full1 & (~full0 | ptr_q);
   assign drive_done = state_q == ST_DRIVE && cnt_q == 3'(WE_HIGH - 1);
   assign gap_done   = state_q == ST_GAP && cnt_q == 3'(WE_GAP - 1);
   always_comb begin
      state_d  = (grant0 | grant1) ? ST_DRIVE : drive_done ? ST_GAP : gap_done ? ST_IDLE : state_q;
      cnt_d    = (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
      ptr_d    = (idle & full0 & full1) ? ~ptr_q : ptr_q;
      drv_d    = grant0 ? slot0 : grant1 ? slot1 : gap_done ? slot_t'('0) : drv_q;
      we_d     = (grant0 | grant1) ? 1'b1 : drive_done ? 1'b0 : we_q;
      shadow_d = drive_done ? apply_update(shadow_q, drv_q) : shadow_q;
   end
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         ptr_q    <= 1'b0;
         drv_q    <= '0;
         we_q     <= 1'b0;
         shadow_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         drv_q    <= drv_d;
         we_q     <= we_d;
         shadow_q <= shadow_d;
      end
   end
   assign bus.status_set_bits   = drv_q.set;
   assign bus.status_reset_bits = drv_q.clr;
   assign bus.status_reset_we   = we_q;
   assign bus.status_shadow     = shadow_q;
   assign bus.busy              = full0 | full1 | ~idle;
endmodule

// File: tb/tb_usb_status_seq.sv
// tb_usb_status_seq: directed self-checking bench for usb_status_seq
module tb_usb_status_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   usb_status_seq_if bus ();
   usb_status_seq #(.WE_HIGH(2), .WE_GAP(3)) dut (.clkin(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      for (int k = 0; k < 40 && bus.busy; k++) tick();
      chk(name, {7'd0, bus.busy}, 8'h00);
   endtask
   initial begin
      bus.req0 = 0; bus.set0 = 0; bus.clr0 = 0;
      bus.req1 = 0; bus.set1 = 0; bus.clr1 = 0;
      tick();
      do_reset();
      chk("rst_we", {7'd0, bus.status_reset_we}, 8'h00);
      chk("rst_set", bus.status_set_bits, 8'h00);
      chk("rst_clr", bus.status_reset_bits, 8'h00);
      chk("rst_shadow", bus.status_shadow, 8'h00);
      chk("rst_busy", {7'd0, bus.busy}, 8'h00);
      chk("rst_acks", {6'd0, bus.ack1, bus.ack0}, 8'h00);
      // single update
      bus.req0 = 1; bus.set0 = 8'h81; bus.clr0 = 8'h00;
      tick();
      chk("s_ack0", {7'd0, bus.ack0}, 8'h01);
      chk("s_we_pre", {7'd0, bus.status_reset_we}, 8'h00);
      bus.req0 = 0;
      tick();
      chk("s_we1", {7'd0, bus.status_reset_we}, 8'h01);
      chk("s_set1", bus.status_set_bits, 8'h81);
      chk("s_ack0_gone", {7'd0, bus.ack0}, 8'h00);
      tick();
      chk("s_we2", {7'd0, bus.status_reset_we}, 8'h01);
      tick();
      chk("s_we_low", {7'd0, bus.status_reset_we}, 8'h00);
      chk("s_shadow", bus.status_shadow, 8'h81);
      chk("s_set_gap", bus.status_set_bits, 8'h81);
      tick();
      tick();
      chk("s_busy_gap", {7'd0, bus.busy}, 8'h01);
      chk("s_we_gap3", {7'd0, bus.status_reset_we}, 8'h00);
      tick();
      chk("s_busy_idle", {7'd0, bus.busy}, 8'h00);
      chk("s_set_idle", bus.status_set_bits, 8'h00);
      // simultaneous requests
      do_reset();
      bus.req0 = 1; bus.set0 = 8'h01; bus.clr0 = 0;
      bus.req1 = 1; bus.set1 = 8'h02; bus.clr1 = 0;
      tick();
      chk("m_acks", {6'd0, bus.ack1, bus.ack0}, 8'h03);
      bus.req0 = 0; bus.req1 = 0;
      tick();
      chk("m_we_a", {7'd0, bus.status_reset_we}, 8'h01);
      chk("m_set_a", bus.status_set_bits, 8'h01);
      for (int k = 0; k < 5; k++) tick();
      chk("m_we_before_b", {7'd0, bus.status_reset_we}, 8'h00);
      tick();
      chk("m_we_b", {7'd0, bus.status_reset_we}, 8'h01);
      chk("m_set_b", bus.status_set_bits, 8'h02);
      wait_idle("m_idle");
      chk("m_shadow", bus.status_shadow, 8'h03);
      // fairness with both requesters held
      do_reset();
      bus.req0 = 1; bus.set0 = 8'h10; bus.clr0 = 0;
      bus.req1 = 1; bus.set1 = 8'h20; bus.clr1 = 0;
      for (int n = 0; n < 8; n++) begin
         logic got, prev;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            prev = bus.status_reset_we;
            tick();
            if (bus.status_reset_we && !prev) got = 1;
         end
         chk("f_rise", {7'd0, got}, 8'h01);
         chk("f_grant", bus.status_set_bits, n[0] ? 8'h20 : 8'h10);
      end
      bus.req0 = 0; bus.req1 = 0;
      wait_idle("f_idle");
      chk("f_shadow", bus.status_shadow, 8'h30);
      // clear precedence
      do_reset();
      bus.req0 = 1; bus.set0 = 8'hFF; bus.clr0 = 0;
      tick();
      bus.req0 = 0;
      wait_idle("c_idle");
      chk("c_shadow_ff", bus.status_shadow, 8'hFF);
      bus.req1 = 1; bus.set1 = 8'h0F; bus.clr1 = 8'h0F;
      tick();
      chk("c_ack1", {7'd0, bus.ack1}, 8'h01);
      bus.req1 = 0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("c_we", {7'd0, bus.status_reset_we}, 8'h01);
         chk("c_set", bus.status_set_bits, 8'h0F);
         chk("c_clr", bus.status_reset_bits, 8'h0F);
      end
      tick();
      chk("c_shadow_f0", bus.status_shadow, 8'hF0);
      wait_idle("c_idle2");
      // backpressure
      do_reset();
      bus.req0 = 1; bus.set0 = 8'h11; bus.clr0 = 0;
      tick();
      chk("b_ack_a", {7'd0, bus.ack0}, 8'h01);
      bus.set0 = 8'h22;
      tick();
      chk("b_grant_a", bus.status_set_bits, 8'h11);
      chk("b_noack_grant", {7'd0, bus.ack0}, 8'h00);
      tick();
      chk("b_ack_b", {7'd0, bus.ack0}, 8'h01);
      bus.set0 = 8'h33;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("b_held", {7'd0, bus.ack0}, 8'h00);
      end
      chk("b_grant_b", bus.status_set_bits, 8'h22);
      chk("b_we_b", {7'd0, bus.status_reset_we}, 8'h01);
      tick();
      chk("b_ack_c", {7'd0, bus.ack0}, 8'h01);
      bus.req0 = 0;
      wait_idle("b_idle");
      chk("b_shadow", bus.status_shadow, 8'h33);
      // reset in the first DRIVE cycle
      bus.req1 = 1; bus.set1 = 8'h55; bus.clr1 = 0;
      tick();
      bus.req1 = 0;
      tick();
      chk("r_we_pre", {7'd0, bus.status_reset_we}, 8'h01);
      rst = 1;
      bus.req0 = 1; bus.set0 = 8'h44;
      tick();
      chk("r_we", {7'd0, bus.status_reset_we}, 8'h00);
      chk("r_set", bus.status_set_bits, 8'h00);
      chk("r_clr", bus.status_reset_bits, 8'h00);
      chk("r_shadow", bus.status_shadow, 8'h00);
      chk("r_busy", {7'd0, bus.busy}, 8'h00);
      rst = 0;
      bus.req0 = 0;
      tick();
      chk("r_noack", {6'd0, bus.ack1, bus.ack0}, 8'h00);
      chk("r_busy_after", {7'd0, bus.busy}, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
